thumb_fetch_buffer: RTL
=======================

// Module: thumb_fetch_buffer
// PURPOSE
//  Parametrised instruction-fetch front end for arm_core. Replaces the combinational pc-indexed
//  halfword array with a pipelined, latency-tolerant halfword prefetch queue. Assembles 16/32-bit
//  Thumb-2 instructions and presents them to pre-decode over a valid/ready handshake.
//  Supports branch flush and counts retired fetches.
// PARAMETERS
//  ADDR_W    21  halfword address width; fetch address wraps modulo 2^ADDR_W
//  DEPTH     4   halfword queue entries; power of two, >=2
//  RESET_PC  0   halfword address fetched first after reset
// PORTS
//  clk          in   1       core clock, all state on posedge
//  rst          in   1       asynchronous, active-low reset
//  mem_req      out  1       halfword read request, one per cycle max
//  mem_addr     out  ADDR_W  halfword address of mem_req
//  mem_rvalid   in   1       read data valid; responses return in request order, any latency >=1
//  mem_rdata    in   16      returned halfword
//  flush        in   1       redirect fetch (branch/exception)
//  flush_addr   in   ADDR_W  new halfword fetch address
//  inst_valid   out  1       complete instruction at queue head
//  inst_ready   in   1       pre-decode accepts inst this cycle
//  inst         out  32      32-bit: {hw0,hw1}; 16-bit: {hw0,16'h0000}
//  inst_is32    out  1       hw0[15:11] is 5'b11101, 5'b11110 or 5'b11111
//  inst_addr    out  ADDR_W  halfword address of hw0
//  inst_count   out  32      accepted-instruction counter, wraps
//  err          out  1       sticky protocol error
// BEHAVIOUR
//  - Reset (rst=0, async): queue empty; outstanding=0; drop_cnt=0; fetch_addr=head_addr=RESET_PC;
//    inst_count=0; err=0. All outputs 0 during reset, except mem_addr=RESET_PC.
//  - Issue: mem_req=1 iff count+outstanding<DEPTH and !flush. mem_addr=fetch_addr.
//    fetch_addr++ per issue. The invariant count+outstanding<=DEPTH always holds, so the queue never overflows.
//  - Response: mem_rvalid with drop_cnt>0 -> discard the response, drop_cnt--. Otherwise push
//    mem_rdata and outstanding--.
//  - Head: inst_valid = (count>=1 & !is32) | (count>=2 & is32). Combinational from registers.
//    inst/inst_is32/inst_addr are valid only while inst_valid=1 and are 0 when count=0.
//  - Accept (inst_valid & inst_ready): pop 1 (16-bit) or 2 (32-bit) entries; head_addr += 1 or 2;
//    inst_count++. Push and pop in the same cycle are both applied; full/empty never block each other.
//  - 32-bit with only hw0 queued: inst_valid=0 and the head is not popped, so no partial issue.
//  - Flush has priority over everything else in its cycle: no accept, no issue, inst_count unchanged.
//    Queue cleared. fetch_addr=head_addr=flush_addr.
//    drop_cnt = outstanding (pre-flush) - (mem_rvalid ? 1 : 0); a response arriving in the flush
//    cycle is discarded.
//    First request to flush_addr goes out the cycle after flush; inst_valid=0 until its data returns.
//  - Back-to-back flushes: the later flush wins; drop_cnt is recomputed with the same rule.
//  - err <= 1 if mem_rvalid arrives while outstanding=0 and drop_cnt=0; the response is ignored.
//    err is cleared only by reset.
//  - Latency: at 1-cycle memory, a 16-bit inst is valid 2 cycles after its mem_req. Sustained rate is
//    1 inst/cycle for 16-bit code; 32-bit code runs at 1 inst per 2 cycles (1 halfword/cycle fetch).
// STRUCTURE
//  - Shared include thumb_defs.vh: HW_W=16; T32 prefix constants 5'b11101/11110/11111;
//    function is_thumb32(hw). pre_dec reuses the same include.
//  - Sub-module hw_fifo: circular DEPTH x 16 queue. Push 1, pop 0/1/2, peek of entries 0 and 1,
//    count, clear. Pointers are log2(DEPTH) bits and wrap.
//  - Top holds fetch_addr, head_addr, outstanding/drop_cnt counters (log2(DEPTH)+1 bits each),
//    inst_count and err.
// TESTING
//  1. Reset release; mem[0]=2001, mem[1]=2102; 1-cycle memory; ready=1 -> mem_req at addr 0 in the
//     first post-reset cycle. inst=20010000, addr 0; next cycle inst=21020000, addr 1. inst_count=2.
//  2. mem[0]=F000, mem[1]=F800, mem[2]=4770 -> inst=F000F800, is32=1, addr 0; then 47700000, addr 2.
//     With hw1 delayed 5 cycles, inst_valid stays 0 throughout the delay.
//  3. DEPTH=4, ready=0 for 12 cycles, 3-cycle memory -> exactly 4 requests issued; count+outstanding<=4
//     every cycle. On ready=1 the instructions stream in address order, none lost or duplicated.
//  4. 3-cycle memory, flush with flush_addr=100 and 2 requests in flight -> the next 2 rvalids are
//     dropped. First inst has inst_addr=100; inst_count is unchanged by the flush.
//  5. rst=0 asserted mid-cycle while streaming -> outputs clear immediately without a clock edge.
//     After release, fetch restarts at RESET_PC and inst_count=0.
//  6. mem_rvalid pulse with nothing outstanding -> err=1 next cycle and stays 1 until rst.
//     The queue is not modified.

Source files
------------

// File: rtl/thumb_fetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : thumb_fetch_buffer_pkg
// Brief   : Shared Thumb-2 fetch definitions: halfword width, 32-bit prefix
//           constants, pop-amount encoding and the 32-bit length decoder.
// Revision: 1.0 - initial release
// ============================================================================
package thumb_fetch_buffer_pkg;

  localparam int HW_W = 16;

  // hw0[15:11] values that mark the first halfword of a 32-bit instruction
  localparam logic [4:0] T32_PFX_A = 5'b11101;
  localparam logic [4:0] T32_PFX_B = 5'b11110;
  localparam logic [4:0] T32_PFX_C = 5'b11111;

  // Number of halfwords retired from the queue head in one cycle
  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_TWO  = 2'd2
  } pop_e;

  function automatic logic is_thumb32(input logic [HW_W-1:0] hw);
    logic [4:0] pfx;
    pfx = hw[HW_W-1 -: 5];
    return (pfx == T32_PFX_A) || (pfx == T32_PFX_B) || (pfx == T32_PFX_C);
  endfunction

endpackage
`default_nettype wire

// File: rtl/thumb_fetch_buffer_hw_fifo.sv
`default_nettype none
// ============================================================================
// Module  : thumb_fetch_buffer_hw_fifo
// Brief   : Circular DEPTH x 16 halfword queue. One push, zero/one/two pops
//           per cycle, peek of the two oldest entries, occupancy count and a
//           synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
module thumb_fetch_buffer_hw_fifo
  import thumb_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      push_i,
  input  logic [HW_W-1:0]           push_data_i,
  input  logic [1:0]                pop_i,
  output logic [HW_W-1:0]           peek0_o,
  output logic [HW_W-1:0]           peek1_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [HW_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   w_pop_n;
  logic [PW-1:0]   w_rd_ptr_p1;

  // Decode pop request into an entry count and advance pointers (pointers wrap)
  always_comb begin
    w_pop_n  = '0;
    if (pop_i == POP_TWO) begin
      w_pop_n = CW'(2);
    end else if (pop_i == POP_ONE) begin
      w_pop_n = CW'(1);
    end
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(w_pop_n);
      wr_ptr_d = wr_ptr_q + PW'(push_i);
      count_d  = count_q + CW'(push_i) - w_pop_n;
    end
  end

  // Pointer and occupancy state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: every read is qualified by the occupancy count
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Peeks read as zero when the slot does not hold valid data
  always_comb begin
    w_rd_ptr_p1 = rd_ptr_q + PW'(1);
    peek0_o     = (count_q != '0)      ? mem_q[rd_ptr_q]    : '0;
    peek1_o     = (count_q >= CW'(2))  ? mem_q[w_rd_ptr_p1] : '0;
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/thumb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module  : thumb_fetch_buffer
// Brief   : Pipelined Thumb-2 instruction fetch front end. Prefetches
//           halfwords over a latency-tolerant in-order memory port, assembles
//           16/32-bit instructions and hands them to pre-decode over
//           valid/ready. Supports branch flush and counts accepted
//           instructions.
// Revision: 1.0 - initial release
// ============================================================================
module thumb_fetch_buffer
  import thumb_fetch_buffer_pkg::*;
#(
  parameter int                ADDR_W   = 21,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rvalid_i,
  input  logic [15:0]       mem_rdata_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_addr_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [31:0]       inst_o,
  output logic              inst_is32_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [31:0]       inst_count_o,
  output logic              err_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  // Stale responses can pile up across chained flushes while older ones are
  // still in flight, so the drop counter gets headroom beyond one queue-full.
  localparam int DW = CW + 2;

  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] head_addr_q, head_addr_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [DW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [31:0]       inst_count_q, inst_count_d;
  logic              err_q, err_d;

  logic [HW_W-1:0]   w_hw0, w_hw1;
  logic [CW-1:0]     w_fifo_count;
  logic              w_has1, w_has2, w_is32, w_inst_valid, w_accept;
  logic [1:0]        w_pop;
  logic [CW:0]       w_occupancy;
  logic              w_issue;
  logic [DW-1:0]     w_in_flight;
  logic              w_resp_live, w_resp_drop, w_resp_stray;

  thumb_fetch_buffer_hw_fifo #(
    .DEPTH (DEPTH)
  ) u_hw_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (flush_i),
    .push_i      (w_resp_live),
    .push_data_i (mem_rdata_i),
    .pop_i       (w_pop),
    .peek0_o     (w_hw0),
    .peek1_o     (w_hw1),
    .count_o     (w_fifo_count)
  );

  // Head decode: a 32-bit instruction is only presented once both halves are queued
  always_comb begin
    w_has1       = (w_fifo_count != '0);
    w_has2       = (w_fifo_count >= CW'(2));
    w_is32       = w_has1 && is_thumb32(w_hw0);
    w_inst_valid = (w_has1 && !w_is32) || (w_has2 && w_is32);
    w_accept     = w_inst_valid && inst_ready_i && !flush_i;
    w_pop        = POP_NONE;
    if (w_accept) begin
      w_pop = w_is32 ? POP_TWO : POP_ONE;
    end
  end

  // Request and response classification; queued plus live in-flight never exceeds DEPTH
  always_comb begin
    w_occupancy  = {1'b0, w_fifo_count} + {1'b0, outstanding_q};
    w_issue      = (w_occupancy < (CW+1)'(DEPTH)) && !flush_i;
    w_in_flight  = DW'(outstanding_q) + drop_cnt_q;
    w_resp_stray = mem_rvalid_i && (outstanding_q == '0) && (drop_cnt_q == '0);
    w_resp_drop  = mem_rvalid_i && !flush_i && (drop_cnt_q != '0);
    w_resp_live  = mem_rvalid_i && !flush_i && (drop_cnt_q == '0) && (outstanding_q != '0);
  end

  // Next-state: flush redirects and turns every in-flight response into a drop
  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    head_addr_d   = head_addr_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    inst_count_d  = inst_count_q;
    err_d         = err_q | w_resp_stray;
    if (flush_i) begin
      fetch_addr_d  = flush_addr_i;
      head_addr_d   = flush_addr_i;
      outstanding_d = '0;
      // The response landing in the flush cycle is the oldest one and is discarded here
      drop_cnt_d    = w_in_flight - DW'(mem_rvalid_i && (w_in_flight != '0));
    end else begin
      fetch_addr_d  = fetch_addr_q + ADDR_W'(w_issue);
      outstanding_d = outstanding_q + CW'(w_issue) - CW'(w_resp_live);
      drop_cnt_d    = drop_cnt_q - DW'(w_resp_drop);
      if (w_accept) begin
        head_addr_d  = head_addr_q + (w_is32 ? ADDR_W'(2) : ADDR_W'(1));
        inst_count_d = inst_count_q + 32'd1;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_addr_q  <= RESET_PC;
      head_addr_q   <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      inst_count_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      fetch_addr_q  <= fetch_addr_d;
      head_addr_q   <= head_addr_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      inst_count_q  <= inst_count_d;
      err_q         <= err_d;
    end
  end

  // Output drive; request is held low while reset is asserted
  always_comb begin
    mem_req_o    = w_issue && rst_ni;
    mem_addr_o   = fetch_addr_q;
    inst_valid_o = w_inst_valid;
    inst_is32_o  = w_is32;
    inst_addr_o  = w_has1 ? head_addr_q : '0;
    inst_o       = '0;
    if (w_has1) begin
      inst_o = w_is32 ? {w_hw0, w_hw1} : {w_hw0, 16'h0000};
    end
    inst_count_o = inst_count_q;
    err_o        = err_q;
  end

endmodule
`default_nettype wire
